// File: rtl/traffic_light_datapath.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_datapath
// Description : Datapath for a two-road (North/East) traffic-light controller.
//               Holds the six lamp registers, runs the interval counter,
//               synchronizes the East car sensor and returns the four status
//               qualifiers that steer the controller FSM.
//               Optional conflict guard: define TRAFFIC_CONFLICT_GUARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_datapath #(
    parameter int CW       = 8,
    parameter int Y_TICKS  = 3,
    parameter int RR_TICKS = 2,
    parameter int NG_TICKS = 8,
    parameter int EG_TICKS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       car,
    input  logic       s_NR,
    input  logic       s_NG,
    input  logic       s_NY,
    input  logic       s_ER,
    input  logic       s_EG,
    input  logic       s_EY,
    input  logic       en_NR,
    input  logic       en_NG,
    input  logic       en_NY,
    input  logic       en_ER,
    input  logic       en_EG,
    input  logic       en_EY,
    input  logic [1:0] s_IC,
    input  logic       en_IC,
    output logic       NR,
    output logic       NG,
    output logic       NY,
    output logic       ER,
    output logic       EG,
    output logic       EY,
    output logic       not_r,
    output logic       c_and_l,
    output logic       en_s,
    output logic       l_or_notc,
    output logic       fault
);

    localparam logic [CW-1:0] c_y_ticks   = CW'(Y_TICKS);
    localparam logic [CW-1:0] c_rr_ticks  = CW'(RR_TICKS);
    localparam logic [CW-1:0] c_ng_ticks  = CW'(NG_TICKS);
    localparam logic [CW-1:0] c_eg_ticks  = CW'(EG_TICKS);
    localparam logic [CW-1:0] c_cnt_one   = CW'(1);
    localparam logic [CW-1:0] c_cnt_max   = {CW{1'b1}};
    // Lamp vector order is {NR, NG, NY, ER, EG, EY}; reset is all-red.
    localparam logic [5:0]    c_lamps_rst = 6'b100100;

    logic [5:0]    lamps_q, lamps_d;
    logic [5:0]    lamp_sel, lamp_en;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] ticks;
    logic [1:0]    last_sel_q, last_sel_d;
    logic [1:0]    car_sync_q, car_sync_d;
    logic          car_s;
    logic          fresh;
    logic          done;

    assign lamp_sel = {s_NR, s_NG, s_NY, s_ER, s_EG, s_EY};
    assign lamp_en  = {en_NR, en_NG, en_NY, en_ER, en_EG, en_EY};
    assign {NR, NG, NY, ER, EG, EY} = lamps_q;
    assign car_s = car_sync_q[1];

`ifdef TRAFFIC_CONFLICT_GUARD_EN
    logic fault_q, fault_d, conflict;

    // Both roads showing a go/caution aspect, or no red anywhere while both move.
    always_comb begin
        conflict = ((NG | NY) & (EG | EY)) |
                   (~NR & ~ER & (NG | NY) & (EG | EY));
        fault_d  = fault_q | conflict;
    end

    // Sticky fault: only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fault_q <= 1'b0;
        else     fault_q <= fault_d;
    end

    // Reported in the same cycle the conflicting lamps are visible.
    assign fault = fault_q | conflict;
`else
    assign fault = 1'b0;
`endif

    // Per-lamp load; a raised fault overrides everything with all-red.
    always_comb begin
        lamps_d = (lamps_q & ~lamp_en) | (lamp_sel & lamp_en);
`ifdef TRAFFIC_CONFLICT_GUARD_EN
        if (fault) lamps_d = c_lamps_rst;
`endif
    end

    // Interval counter: reload on a new select, otherwise count up and saturate.
    always_comb begin
        fresh      = en_IC & (s_IC != last_sel_q);
        cnt_d      = cnt_q;
        last_sel_d = last_sel_q;
        if (fresh) begin
            cnt_d      = c_cnt_one;
            last_sel_d = s_IC;
        end else if (en_IC && (cnt_q != c_cnt_max)) begin
            cnt_d = cnt_q + c_cnt_one;
        end
    end

    // Interval length for the active select, then the four status qualifiers.
    always_comb begin
        case (s_IC)
            2'b00:   ticks = c_y_ticks;
            2'b01:   ticks = c_rr_ticks;
            2'b10:   ticks = c_ng_ticks;
            default: ticks = c_eg_ticks;
        endcase
        done      = en_IC & ~fresh & (cnt_q >= ticks);
        en_s      = done & (s_IC == 2'b00);
        not_r     = done & (s_IC == 2'b01);
        c_and_l   = done & (s_IC == 2'b10) & car_s;
        l_or_notc = (s_IC == 2'b11) & en_IC & ~fresh & (done | ~car_s);
    end

    // Two-flop synchronizer for the asynchronous car sensor.
    always_comb begin
        car_sync_d = {car_sync_q[0], car};
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lamps_q    <= c_lamps_rst;
            cnt_q      <= '0;
            last_sel_q <= 2'b00;
            car_sync_q <= 2'b00;
        end else begin
            lamps_q    <= lamps_d;
            cnt_q      <= cnt_d;
            last_sel_q <= last_sel_d;
            car_sync_q <= car_sync_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_light_datapath
// Description : Self-checking bench for traffic_light_datapath. A cycle model
//               predicts every output each cycle; predictions are queued when
//               stimulus is applied and compared when the DUT is sampled.
//               Conflict-guard checks follow TRAFFIC_CONFLICT_GUARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_datapath;

    localparam int CW       = 8;
    localparam int Y_TICKS  = 3;
    localparam int RR_TICKS = 2;
    localparam int NG_TICKS = 8;
    localparam int EG_TICKS = 5;
    localparam int CNT_MAX  = (1 << CW) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       car = 1'b0;
    logic       s_NR = 0, s_NG = 0, s_NY = 0, s_ER = 0, s_EG = 0, s_EY = 0;
    logic       en_NR = 0, en_NG = 0, en_NY = 0, en_ER = 0, en_EG = 0, en_EY = 0;
    logic [1:0] s_IC = 2'b00;
    logic       en_IC = 1'b0;
    logic       NR, NG, NY, ER, EG, EY;
    logic       not_r, c_and_l, en_s, l_or_notc, fault;

    traffic_light_datapath #(
        .CW(CW), .Y_TICKS(Y_TICKS), .RR_TICKS(RR_TICKS),
        .NG_TICKS(NG_TICKS), .EG_TICKS(EG_TICKS)
    ) dut (
        .clk(clk), .rst(rst), .car(car),
        .s_NR(s_NR), .s_NG(s_NG), .s_NY(s_NY), .s_ER(s_ER), .s_EG(s_EG), .s_EY(s_EY),
        .en_NR(en_NR), .en_NG(en_NG), .en_NY(en_NY), .en_ER(en_ER), .en_EG(en_EG), .en_EY(en_EY),
        .s_IC(s_IC), .en_IC(en_IC),
        .NR(NR), .NG(NG), .NY(NY), .ER(ER), .EG(EG), .EY(EY),
        .not_r(not_r), .c_and_l(c_and_l), .en_s(en_s), .l_or_notc(l_or_notc),
        .fault(fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Observed vector: [10:5] lamps {NR,NG,NY,ER,EG,EY}, [4] not_r,
    // [3] c_and_l, [2] en_s, [1] l_or_notc, [0] fault.
    logic [10:0] obs;
    logic [10:0] exp_q[$];

    // Reference model state.
    logic [5:0] m_lamps;
    int         m_cnt;
    logic [1:0] m_last;
    logic       m_s1, m_s2;
    logic       m_fault;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
        end
    endtask

    task automatic model_reset();
        m_lamps = 6'b100100;
        m_cnt   = 0;
        m_last  = 2'b00;
        m_s1    = 1'b0;
        m_s2    = 1'b0;
        m_fault = 1'b0;
    endtask

    function automatic logic m_conflict();
        logic go_n, go_e;
        go_n = m_lamps[4] | m_lamps[3];
        go_e = m_lamps[1] | m_lamps[0];
        return (go_n & go_e) | (~m_lamps[5] & ~m_lamps[2] & go_n & go_e);
    endfunction

    function automatic logic m_fault_out();
`ifdef TRAFFIC_CONFLICT_GUARD_EN
        return m_fault | m_conflict();
`else
        return 1'b0;
`endif
    endfunction

    function automatic int m_ticks(input logic [1:0] sel);
        case (sel)
            2'b00:   return Y_TICKS;
            2'b01:   return RR_TICKS;
            2'b10:   return NG_TICKS;
            default: return EG_TICKS;
        endcase
    endfunction

    function automatic logic [10:0] model_out();
        logic fr, dn;
        logic [3:0] st;
        fr = en_IC && (s_IC != m_last);
        dn = en_IC && !fr && (m_cnt >= m_ticks(s_IC));
        st[3] = dn && (s_IC == 2'b01);
        st[2] = dn && (s_IC == 2'b10) && m_s2;
        st[1] = dn && (s_IC == 2'b00);
        st[0] = (s_IC == 2'b11) && en_IC && !fr && (dn || !m_s2);
        return {m_lamps, st, m_fault_out()};
    endfunction

    task automatic model_update();
        logic [5:0] sel, en;
        logic       fr, fo;
        sel = {s_NR, s_NG, s_NY, s_ER, s_EG, s_EY};
        en  = {en_NR, en_NG, en_NY, en_ER, en_EG, en_EY};
        fr  = en_IC && (s_IC != m_last);
        fo  = m_fault_out();
`ifdef TRAFFIC_CONFLICT_GUARD_EN
        m_fault = m_fault | m_conflict();
`endif
        if (fo) m_lamps = 6'b100100;
        else    m_lamps = (m_lamps & ~en) | (sel & en);
        if (fr) begin
            m_cnt  = 1;
            m_last = s_IC;
        end else if (en_IC && m_cnt < CNT_MAX) begin
            m_cnt = m_cnt + 1;
        end
        m_s2 = m_s1;
        m_s1 = car;
    endtask

    // One clock cycle: predict, sample mid-cycle, compare, advance the model.
    task automatic step(input string tag);
        logic [10:0] e;
        exp_q.push_back(model_out());
        @(negedge clk);
        obs = {NR, NG, NY, ER, EG, EY, not_r, c_and_l, en_s, l_or_notc, fault};
        e = exp_q.pop_front();
        check_val(tag, obs, e);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_lamps(input logic [5:0] s, input logic [5:0] en);
        {s_NR, s_NG, s_NY, s_ER, s_EG, s_EY}       = s;
        {en_NR, en_NG, en_NY, en_ER, en_EG, en_EY} = en;
    endtask

    // Asynchronous reset applied between edges; effect must be immediate.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_val("rst_lamps", {NR, NG, NY, ER, EG, EY}, 6'b100100);
        check_val("rst_status", {not_r, c_and_l, en_s, l_or_notc, fault}, 5'b00000);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1. Reset mid-interval, then all-red timing from last_sel=00.
        set_lamps(6'b010000, 6'b110000);
        s_IC = 2'b10; en_IC = 1'b1;
        step("pre_rst_load");
        set_lamps(6'b000000, 6'b000000);
        for (int i = 0; i < 4; i++) step("pre_rst_cnt");
        do_reset();
        s_IC = 2'b01;
        for (int i = 0; i < 3; i++) begin
            step("rr_after_rst");
            check_val("rr_done_edge", obs[4], (i == 2) ? 1 : 0);
        end

        // 2. Yellow timing, then switch to all-red.
        s_IC = 2'b10;
        step("pre_y");
        step("pre_y");
        s_IC = 2'b00;
        for (int i = 0; i < 4; i++) begin
            step("yellow");
            check_val("en_s_edge", obs[2], (i == 3) ? 1 : 0);
        end
        s_IC = 2'b01;
        step("y_to_rr");
        check_val("y_to_rr_zero", {obs[4], obs[2]}, 2'b00);

        // 3. North green: car arrives at cycle 3, qualifier at cycle 8.
        s_IC = 2'b10; car = 1'b0;
        for (int i = 0; i < 10; i++) begin
            car = (i >= 3);
            step("ng_car");
            if (i == 7) check_val("ng_c7", obs[3], 1'b0);
            if (i == 8) check_val("ng_c8", obs[3], 1'b1);
        end
        // Long North green without a car; car appears just past the
        // saturation point where a wrapping counter would read below NG_TICKS.
        car = 1'b0; s_IC = 2'b11;
        step("ng_switch");
        s_IC = 2'b10;
        for (int i = 0; i < 275; i++) begin
            car = (i >= 255);
            step("ng_sat");
            if (i == 254) check_val("ng_nocar", obs[3], 1'b0);
            if (i == 260) check_val("ng_saturate", obs[3], 1'b1);
        end

        // 4. East green with a car: max-green at cycle 5.
        s_IC = 2'b11; car = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step("eg_car");
            if (i == 4) check_val("eg_c4", obs[1], 1'b0);
            if (i == 5) check_val("eg_c5", obs[1], 1'b1);
        end
        s_IC = 2'b00;
        step("eg_switch");
        s_IC = 2'b11;
        for (int i = 0; i < 5; i++) begin
            car = (i == 0);
            step("eg_drop");
            if (i == 2) check_val("eg_drop_c2", obs[1], 1'b0);
            if (i == 3) check_val("eg_drop_c3", obs[1], 1'b1);
        end

        // 5. Lamp load and hold.
        en_IC = 1'b0;
        set_lamps(6'b010000, 6'b010000);
        step("ng_load");
        set_lamps(6'b000000, 6'b000000);
        step("ng_loaded");
        check_val("ng_on", obs[9], 1'b1);
        for (int i = 0; i < 3; i++) begin
            s_NG = i[0];
            step("ng_hold");
            check_val("ng_hold_val", obs[9], 1'b1);
        end
        set_lamps(6'b100100, 6'b111111);
        step("lamps_back");

`ifndef TRAFFIC_CONFLICT_GUARD_EN
        // Mixed random traffic against the model.
        for (int i = 0; i < 60; i++) begin
            s_IC  = 2'($urandom_range(0, 3));
            en_IC = 1'($urandom_range(0, 3) != 0);
            car   = 1'($urandom_range(0, 1));
            set_lamps(6'($urandom), 6'($urandom));
            step("random");
        end
        set_lamps(6'b000000, 6'b000000);
        en_IC = 1'b0;
`endif

        // 6. Conflicting lamps.
        set_lamps(6'b010010, 6'b111111);
        step("conf_load");
        set_lamps(6'b000000, 6'b000000);
        step("conf_seen");
`ifdef TRAFFIC_CONFLICT_GUARD_EN
        check_val("fault_same_cycle", obs[0], 1'b1);
`else
        check_val("fault_tied_low", obs[0], 1'b0);
`endif
        step("conf_next");
`ifdef TRAFFIC_CONFLICT_GUARD_EN
        check_val("fault_all_red", obs[10:5], 6'b100100);
`else
        check_val("no_guard_hold", obs[10:5], 6'b010010);
`endif
        set_lamps(6'b010000, 6'b010000);
        step("conf_retry");
        set_lamps(6'b000000, 6'b000000);
        step("conf_after");
`ifdef TRAFFIC_CONFLICT_GUARD_EN
        check_val("fault_sticky", {obs[10:5], obs[0]}, 7'b1001001);
`endif
        do_reset();
        step("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/traffic_light_datapath.md
Name: traffic_light_datapath

Overview:
- Datapath for the two-road (North/East) traffic-light controller FSM.
- Consumes the controller's per-lamp select/enable pairs and the 2-bit interval-counter select (s_IC/en_IC).
- Holds the six lamp registers, runs the interval counter and synchronizes the East car sensor.
- Returns the four status qualifiers (not_r, c_and_l, en_s, l_or_notc) that drive the controller's transitions.

Parameters:
- CW, 8: interval counter width; all *_TICKS values must be >=1 and <=2^CW-1.
- Y_TICKS, 3: yellow interval in cycles (s_IC=2'b00).
- RR_TICKS, 2: all-red clearance interval (s_IC=2'b01).
- NG_TICKS, 8: minimum North green before yielding to a waiting car (s_IC=2'b10).
- EG_TICKS, 5: maximum East green (s_IC=2'b11).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- car  in  1  East-road car sensor, asynchronous, level.
- s_NR, s_NG, s_NY, s_ER, s_EG, s_EY  in  1 each  next value for the lamp.
- en_NR, en_NG, en_NY, en_ER, en_EG, en_EY  in  1 each  load enable for the lamp.
- s_IC  in  2  interval select: 00 yellow, 01 all-red, 10 North green, 11 East green.
- en_IC  in  1  interval counter enable.
- NR, NG, NY, ER, EG, EY  out  1 each  registered lamp drives.
- not_r  out  1  all-red interval done.
- c_and_l  out  1  car waiting and North minimum green done.
- en_s  out  1  yellow interval done.
- l_or_notc  out  1  East maximum green done, or no car waiting.
- fault  out  1  sticky conflict flag (see Optional Feature).

Behaviour:
Reset (async on rst high):
- NR=1, ER=1; NG, NY, EG, EY = 0 (all-red).
- cnt=0, last_sel=2'b00, car sync flops = 0, fault=0.

Lamps:
- On each posedge, X <= s_X when en_X=1; otherwise X holds.
- Latency from select to lamp is one cycle.

Car sensor:
- Two-flop synchronizer; car_s is the second flop's output.
- car_s changes 2 cycles after car.

Interval counter:
- fresh = en_IC & (s_IC != last_sel).
- On posedge, when fresh: cnt <= 1 and last_sel <= s_IC.
- Otherwise, when en_IC=1 and cnt != 2^CW-1: cnt <= cnt+1. The counter saturates at 2^CW-1 and never wraps.
- When en_IC=0, cnt and last_sel hold.
- T(sel) selects among Y_TICKS, RR_TICKS, NG_TICKS and EG_TICKS.
- done = en_IC & ~fresh & (cnt >= T(s_IC)).

Status outputs (combinational from registers and s_IC; all forced 0 when en_IC=0 or fresh=1):
- en_s = done & (s_IC==00).
- not_r = done & (s_IC==01).
- c_and_l = done & (s_IC==10) & car_s.
- l_or_notc = (s_IC==11) & en_IC & ~fresh & (done | ~car_s).

Timing and boundary cases:
- A select first seen in cycle k gives done in cycle k+T, so the controller's state lasts T+1 cycles.
- Back-to-back states with the same select (RR1 then RR2, or YR then RY) do not retrigger the counter; the controller always passes through a different select between them.
- A select change in the same cycle the count saturates is still treated as fresh: the reload wins.
- Reset asserted mid-interval returns everything to the reset values immediately. The first select after release compares against last_sel=00.

Optional Feature:
Macro TRAFFIC_CONFLICT_GUARD_EN.
- Defined: each cycle, if (NG|NY) & (EG|EY), or NR=ER=0 with any of NG/NY/EG/EY set on both roads, then fault is set.
- fault is sticky until rst.
- While fault=1, lamp updates are suppressed and the lamps are forced to the reset all-red values on the next edge.
- Not defined: fault is tied to 0 and no checking logic is present.

Test Plan:
1. Reset: rst=1 mid-count (cnt=5) -> immediately NR=ER=1, others 0, cnt=0, all status 0. Release rst and drive s_IC=01, en_IC=1 -> not_r=1 exactly 2 cycles later (RR_TICKS=2).
2. Yellow timing: hold s_IC=00 from cycle 10 (previous select 10) -> en_s low in cycles 10-12, high in cycle 13. Switching to s_IC=01 in cycle 14 -> en_s=0 and not_r=0 in cycle 14.
3. North green with car: s_IC=10; raise car at cycle 3 of the interval -> c_and_l=1 at cycle 8 (NG_TICKS). With car=0 throughout -> c_and_l stays 0 for 300 cycles and cnt saturates at 255 without wrapping.
4. East green: s_IC=11 with car_s=1 -> l_or_notc=1 at cycle 5. Drop car at cycle 1 -> l_or_notc=1 two cycles after the drop, before cycle 5.
5. Lamps: s_NG=1, en_NG=1 for one cycle -> NG=1 on the next cycle. en_NG=0 with s_NG toggling -> NG holds.
6. With TRAFFIC_CONFLICT_GUARD_EN: load NG=1 and EG=1 -> fault=1 in the same cycle, all-red on the next edge, and fault stays 1 until rst.
